// File: rtl/antirrebote_entradas_if.sv
// Raw-input / debounced-output bundle of antirrebote_entradas.
// The master drives the raw inputs; the slave returns the clean levels and edge pulses.
interface antirrebote_entradas_if #(
  parameter int ANCHO = 2
);
  logic [ANCHO-1:0] entrada;
  logic [ANCHO-1:0] salida;
  logic [ANCHO-1:0] flanco_sub;
  logic [ANCHO-1:0] flanco_baj;

  modport master (output entrada, input salida, input flanco_sub, input flanco_baj);
  modport slave  (input entrada, output salida, output flanco_sub, output flanco_baj);
endinterface

// File: rtl/antirrebote_entradas.sv
// Per-channel 2-FF synchroniser plus 4-state debounce FSM feeding the gate inputs.
// Optional macro PULSOS_FLANCO_EN adds registered one-cycle rise/fall pulses.
module antirrebote_entradas #(
  parameter int ANCHO           = 2,
  parameter int CICLOS_ESTABLES = 500000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  antirrebote_entradas_if.slave bus
);

  localparam int CW = $clog2(CICLOS_ESTABLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(CICLOS_ESTABLES);
  localparam logic [CW-1:0] CNT_OBJ = CW'(CICLOS_ESTABLES - 1);
  localparam logic [CW-1:0] CNT_CERO = CW'(0);
  localparam logic [CW-1:0] CNT_UNO  = CW'(1);
  localparam logic DIRECTO = (CICLOS_ESTABLES == 1);

  localparam logic [1:0] ESTABLE_0   = 2'd0;
  localparam logic [1:0] VALIDANDO_1 = 2'd1;
  localparam logic [1:0] ESTABLE_1   = 2'd2;
  localparam logic [1:0] VALIDANDO_0 = 2'd3;

  logic [ANCHO-1:0] salida_v_s;
  logic [ANCHO-1:0] sub_v_s;
  logic [ANCHO-1:0] baj_v_s;

  for (genvar i = 0; i < ANCHO; i++) begin : g_canal
    logic [1:0]    sinc_r;
    logic          sinc_s;
    logic [1:0]    estado_r, estado_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic          salida_r, salida_s;

    assign sinc_s = sinc_r[1];

    // Two-stage synchroniser for the asynchronous raw input
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sinc_r <= 2'b00;
      end else begin
        sinc_r <= {sinc_r[0], bus.entrada[i]};
      end
    end

    // Next-state logic: the count restarts on every state entry and never wraps
    always_comb begin
      estado_s = estado_r;
      cnt_s    = cnt_r;
      salida_s = salida_r;
      case (estado_r)
        ESTABLE_0: begin
          salida_s = 1'b0;
          if (sinc_s && DIRECTO) begin
            estado_s = ESTABLE_1;
            cnt_s    = CNT_CERO;
            salida_s = 1'b1;
          end else if (sinc_s) begin
            estado_s = VALIDANDO_1;
            cnt_s    = CNT_UNO;
          end else begin
            cnt_s    = CNT_CERO;
          end
        end
        VALIDANDO_1: begin
          if (!sinc_s) begin
            estado_s = ESTABLE_0;
            cnt_s    = CNT_CERO;
          end else if (cnt_r >= CNT_OBJ) begin
            estado_s = ESTABLE_1;
            cnt_s    = CNT_CERO;
            salida_s = 1'b1;
          end else if (cnt_r != CNT_MAX) begin
            cnt_s    = cnt_r + CNT_UNO;
          end else begin
            cnt_s    = cnt_r;
          end
        end
        ESTABLE_1: begin
          salida_s = 1'b1;
          if (!sinc_s && DIRECTO) begin
            estado_s = ESTABLE_0;
            cnt_s    = CNT_CERO;
            salida_s = 1'b0;
          end else if (!sinc_s) begin
            estado_s = VALIDANDO_0;
            cnt_s    = CNT_UNO;
          end else begin
            cnt_s    = CNT_CERO;
          end
        end
        VALIDANDO_0: begin
          if (sinc_s) begin
            estado_s = ESTABLE_1;
            cnt_s    = CNT_CERO;
          end else if (cnt_r >= CNT_OBJ) begin
            estado_s = ESTABLE_0;
            cnt_s    = CNT_CERO;
            salida_s = 1'b0;
          end else if (cnt_r != CNT_MAX) begin
            cnt_s    = cnt_r + CNT_UNO;
          end else begin
            cnt_s    = cnt_r;
          end
        end
        default: begin
          estado_s = ESTABLE_0;
          cnt_s    = CNT_CERO;
          salida_s = 1'b0;
        end
      endcase
    end

    // FSM, counter and clean-level registers
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        estado_r <= ESTABLE_0;
        cnt_r    <= CNT_CERO;
        salida_r <= 1'b0;
      end else begin
        estado_r <= estado_s;
        cnt_r    <= cnt_s;
        salida_r <= salida_s;
      end
    end

    assign salida_v_s[i] = salida_r;

`ifdef PULSOS_FLANCO_EN
    logic sub_r, baj_r;

    // Edge pulses registered on the same edge that updates salida
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sub_r <= 1'b0;
        baj_r <= 1'b0;
      end else begin
        sub_r <= salida_s & ~salida_r;
        baj_r <= ~salida_s & salida_r;
      end
    end

    assign sub_v_s[i] = sub_r;
    assign baj_v_s[i] = baj_r;
`else
    assign sub_v_s[i] = 1'b0;
    assign baj_v_s[i] = 1'b0;
`endif
  end

  assign bus.salida     = salida_v_s;
  assign bus.flanco_sub = sub_v_s;
  assign bus.flanco_baj = baj_v_s;

endmodule
